alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits; legal range is 8..64, powers of two only.
REQ-002 Parameter SHW, default $clog2(WIDTH), SHALL set the shift-amount field width.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port start, input, 1 bit, SHALL be the operation request; it is sampled only in IDLE.
REQ-006 Port ALUOp, input, 5 bits, SHALL carry the operation code (REQ-013).
REQ-007 Port A, input, WIDTH bits, signed, SHALL be operand A; it is also the shift amount source.
REQ-008 Port B, input, WIDTH bits, signed, SHALL be operand B.
REQ-009 Port C, output, WIDTH bits, registered, SHALL be the result.
REQ-010 Port Zero, output, 1 bit, SHALL be high exactly when C == 0.
REQ-011 Ports Overflow, DivZero, busy and done, outputs, 1 bit each, SHALL be registered status flags.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 ALUOp decode SHALL be:
- 0 NOP: C=A
- 1 ADD, 2 SUB
- 3 AND, 4 OR, 8 NOR, 11 XOR
- 5 SLT (signed), 6 SLTU (unsigned)
- 7 SLL, 9 SRL, 10 SRA: C = B shifted by A[SHW-1:0]
- 12 MUL (low WIDTH bits), 13 MULHU (high WIDTH bits, unsigned)
- 14 DIVU, 15 REMU
- 16..31: behave as NOP
REQ-014 On start=1 in IDLE, the block SHALL latch A, B and ALUOp at that edge; later changes on these inputs SHALL not affect the operation in flight.
REQ-015 Ops 0..11 and 16..31 (single-cycle) SHALL:
- write C, Overflow and DivZero on the accepting edge;
- go IDLE→DONE;
- assert done in the next cycle (latency 1).
REQ-016 Ops 12..15 (iterative) SHALL:
- go IDLE→RUN on the accepting edge and clear the iteration counter;
- perform one iteration per cycle in RUN: shift-add for MUL/MULHU, restoring for DIVU/REMU;
- after exactly WIDTH RUN cycles, write C and go DONE;
- have done high WIDTH+1 cycles after the accepting edge.
REQ-017 DONE SHALL last exactly one cycle, with done=1 for that cycle, then go to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly while state==RUN.
REQ-019 start SHALL be ignored in RUN and DONE; a new request is accepted earliest in the IDLE cycle after done.
REQ-020 C, Overflow and DivZero SHALL hold their values until the next result write.
REQ-021 Overflow SHALL be signed two's-complement overflow for ADD/SUB, and 0 for every other op.
REQ-022 For DIVU/REMU with B==0, the block SHALL:
- still run WIDTH cycles;
- return C = all ones for DIVU and C = A for REMU;
- set DivZero=1.
DivZero SHALL be 0 for every other case.
REQ-023 Shift amounts SHALL use only A[SHW-1:0]; upper bits of A are ignored.
REQ-024 SRA SHALL fill with B's sign bit.
REQ-025 SLT/SLTU SHALL produce C=1 or C=0, zero-extended to WIDTH.

Reset
REQ-026 With rst=1 at a rising edge, the block SHALL set state=IDLE, C=0, Overflow=0, DivZero=0, busy=0, done=0 and the counter to 0; Zero then reads 1.
REQ-027 rst SHALL override start in the same cycle; no operation is accepted.
REQ-028 rst during RUN or DONE SHALL abort the operation; no done pulse follows.

Verification (WIDTH=32)
REQ-029 The bench SHALL cover these directed scenarios:
- ADD, A=32'h7FFFFFFF, B=1, start for one cycle → next cycle done=1, C=32'h80000000, Overflow=1, Zero=0.
- SRA, A=4, B=32'h80000000 → C=32'hF8000000. SLL, A=32'h21, B=1 → C=2 (amount is 1).
- MULHU, A=B=32'hFFFFFFFF → busy=1 for 32 cycles, done 33 cycles after start, C=32'hFFFFFFFE. MUL on the same operands → C=1.
- DIVU, A=100, B=7 → C=14 after 33 cycles. REMU, same operands → C=2. DIVU with B=0 → C=32'hFFFFFFFF, DivZero=1.
- start held high continuously with ADD A=1, B=1 → done pulses every 2 cycles, C=2; start is ignored during DONE.
- rst asserted at cycle 10 of a DIVU → next cycle busy=0, C=0, Zero=1, and no done pulse afterwards.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add
// multiply and restoring divide sharing one hi/lo working register pair.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4:0]              ALUOp,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic signed [WIDTH-1:0] C,
    output logic                    Zero,
    output logic                    Overflow,
    output logic                    DivZero,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,  OP_ADD   = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3,
        OP_OR   = 5'd4,  OP_SLT   = 5'd5,  OP_SLTU = 5'd6,  OP_SLL  = 5'd7,
        OP_NOR  = 5'd8,  OP_SRL   = 5'd9,  OP_SRA  = 5'd10, OP_XOR  = 5'd11,
        OP_MUL  = 5'd12, OP_MULHU = 5'd13, OP_DIVU = 5'd14, OP_REMU = 5'd15
    } op_e;

    state_t             state_q;
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   c_q, b_q, hi_q, lo_q;
    logic               ovf_q, dz_q, busy_q, done_q;
    logic [SHW-1:0]     cnt_q;

    logic [WIDTH-1:0]   a_u, b_u, sum, dif, alu_res;
    logic               alu_ovf;
    logic [SHW-1:0]     shamt;
    logic               start_iter;

    assign a_u        = A;
    assign b_u        = B;
    assign sum        = a_u + b_u;
    assign dif        = a_u - b_u;
    assign shamt      = a_u[SHW-1:0];
    assign start_iter = (ALUOp[4:2] == 3'b011);  // opcodes 12..15

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        alu_res = a_u;
        alu_ovf = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a_u[WIDTH-1] == b_u[WIDTH-1]) && (sum[WIDTH-1] != a_u[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (a_u[WIDTH-1] != b_u[WIDTH-1]) && (dif[WIDTH-1] != a_u[WIDTH-1]);
            end
            OP_AND:  alu_res = a_u & b_u;
            OP_OR:   alu_res = a_u | b_u;
            OP_NOR:  alu_res = ~(a_u | b_u);
            OP_XOR:  alu_res = a_u ^ b_u;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_u) < $signed(b_u))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_u < b_u)};
            OP_SLL:  alu_res = b_u << shamt;
            OP_SRL:  alu_res = b_u >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(b_u) >>> shamt);
            default: alu_res = a_u;
        endcase
    end

    // One iteration step: hi holds the partial product / remainder, lo the multiplier / quotient.
    logic [WIDTH:0]   mul_sum, rem_sh;
    logic [WIDTH-1:0] rem_sub, hi_d, lo_d, iter_res;
    logic             div_op;

    assign div_op   = (op_q == OP_DIVU) || (op_q == OP_REMU);
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rem_sh   = {hi_q, lo_q[WIDTH-1]};
    assign rem_sub  = rem_sh[WIDTH-1:0] - b_q;

    always_comb begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (div_op) begin
            if (rem_sh >= {1'b0, b_q}) begin
                hi_d = rem_sub;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // A zero divisor always subtracts, so the quotient saturates to all ones and the remainder ends as A.
    assign iter_res = (op_q == OP_MULHU || op_q == OP_REMU) ? hi_d : lo_d;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            c_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q  <= ALUOp;
                        b_q   <= b_u;
                        lo_q  <= a_u;
                        hi_q  <= '0;
                        cnt_q <= '0;
                        if (start_iter) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            c_q     <= alu_res;
                            ovf_q   <= alu_ovf;
                            dz_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(WIDTH-1)) begin
                        c_q     <= iter_res;
                        ovf_q   <= 1'b0;
                        dz_q    <= div_op && (b_q == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign C        = c_q;
    assign Zero     = (c_q == '0);
    assign Overflow = ovf_q;
    assign DivZero  = dz_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [4:0]  ALUOp;
    logic [31:0] A, B, C;
    logic        Zero, Overflow, DivZero, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUOp(ALUOp), .A(A), .B(B),
        .C(C), .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected result straight from the op definitions.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic ovf, output logic dz,
                                  output bit iter);
        longint      sa, sb, s;
        logic [63:0] p;
        int          n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(a[4:0]);
        p  = {32'b0, a} * {32'b0, b};
        c = a; ovf = 1'b0; dz = 1'b0; iter = (op >= 5'd12 && op <= 5'd15);
        case (op)
            5'd1:  begin s = sa + sb; c = s[31:0]; ovf = (s > MAX_S) || (s < MIN_S); end
            5'd2:  begin s = sa - sb; c = s[31:0]; ovf = (s > MAX_S) || (s < MIN_S); end
            5'd3:  c = a & b;
            5'd4:  c = a | b;
            5'd8:  c = ~(a | b);
            5'd11: c = a ^ b;
            5'd5:  c = (sa < sb) ? 32'd1 : 32'd0;
            5'd6:  c = (a < b) ? 32'd1 : 32'd0;
            5'd7:  c = b << n;
            5'd9:  c = b >> n;
            5'd10: c = (b >> n) | (b[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
            5'd12: c = p[31:0];
            5'd13: c = p[63:32];
            5'd14: begin c = (b == 0) ? 32'hFFFF_FFFF : a / b; dz = (b == 0); end
            5'd15: begin c = (b == 0) ? a : a % b;            dz = (b == 0); end
            default: c = a;
        endcase
    endfunction

    // Issue one op from an IDLE negedge; inputs are scrambled after acceptance.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] c_got);
        logic [31:0] ec;
        logic        eo, ed;
        bit          it, seen;
        int          lat, nbusy;
        model(op, a, b, ec, eo, ed, it);
        start = 1'b1; ALUOp = op; A = a; B = b;
        @(posedge clk);
        lat = 0; nbusy = 0; seen = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1;
            else if (busy) nbusy++;
            start = 1'($urandom); ALUOp = 5'($urandom); A = $urandom; B = $urandom;
        end
        check({tag, " latency"}, 64'(lat), it ? 64'd33 : 64'd1);
        check({tag, " busy_cycles"}, 64'(nbusy), it ? 64'd32 : 64'd0);
        check({tag, " C"}, 64'(C), 64'(ec));
        check({tag, " Overflow"}, 64'(Overflow), 64'(eo));
        check({tag, " DivZero"}, 64'(DivZero), 64'(ed));
        check({tag, " Zero"}, 64'(Zero), 64'(ec == 0));
        c_got = C;
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_one_cycle"}, 64'(done), 64'd0);
        check({tag, " C_hold"}, 64'(C), 64'(ec));
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, exp_c;
    } dir_t;

    dir_t dir_tab[] = '{
        '{5'd1,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000},
        '{5'd10, 32'h4,         32'h8000_0000, 32'hF800_0000},
        '{5'd7,  32'h21,        32'h1,         32'h2},
        '{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1},
        '{5'd14, 32'd100,       32'd7,         32'd14},
        '{5'd15, 32'd100,       32'd7,         32'd2},
        '{5'd14, 32'd100,       32'd0,         32'hFFFF_FFFF},
        '{5'd15, 32'd100,       32'd0,         32'd100},
        '{5'd2,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF},
        '{5'd5,  32'hFFFF_FFFF, 32'h1,         32'h1},
        '{5'd6,  32'hFFFF_FFFF, 32'h1,         32'h0},
        '{5'd20, 32'h5,         32'h9,         32'h5}
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cg;
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        int          ndone;

        // Reset overrides a simultaneous start.
        rst = 1'b1; start = 1'b1; ALUOp = 5'd1; A = 32'd5; B = 32'd5;
        repeat (3) @(negedge clk);
        check("reset C", 64'(C), 64'd0);
        check("reset Zero", 64'(Zero), 64'd1);
        check("reset flags", {60'd0, Overflow, DivZero, busy, done}, 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("no accept after reset", 64'(done), 64'd0);

        foreach (dir_tab[i]) begin
            run_op($sformatf("dir%0d", i), dir_tab[i].op, dir_tab[i].a, dir_tab[i].b, cg);
            check($sformatf("dir%0d spec_C", i), 64'(cg), 64'(dir_tab[i].exp_c));
        end

        // start held high: an accept every other cycle, DONE ignores start.
        start = 1'b1; ALUOp = 5'd1; A = 32'd1; B = 32'd1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("held done%0d", i), 64'(done), 64'((i % 2) == 0));
            if (i == 7) start = 1'b0;
        end
        check("held C", 64'(C), 64'd2);

        for (int k = 0; k < 60; k++) begin
            rop = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rop = 5'($urandom_range(12, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) ra = 32'h7FFF_FFFF;
            if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
            run_op($sformatf("rnd%0d op%0d", k, rop), rop, ra, rb, cg);
        end

        // Reset in the middle of a divide aborts it without a done pulse.
        start = 1'b1; ALUOp = 5'd14; A = 32'd100; B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort C", 64'(C), 64'd0);
        check("abort Zero", 64'(Zero), 64'd1);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no_done", 64'(ndone), 64'd0);

        run_op("post_abort", 5'd14, 32'd1000, 32'd9, cg);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
